// File: rtl/pt226x_encoder_gen2.sv
// PT2262-style tri-state encoder with start/busy handshake,
// frame repeat count and continuous (key-held) transmission.
module pt226x_encoder_gen2 #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 4,
    parameter int ALPHA_CYC = 4,
    parameter int REPEAT    = 4,
    localparam int DW = (DATA_BITS > 0) ? DATA_BITS : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [ADDR_BITS-1:0] addr_val,
    input  logic [ADDR_BITS-1:0] addr_float,
    input  logic [DW-1:0]        data,
    output logic                 busy,
    output logic                 sync,
    output logic                 frame_done,
    output logic                 cod_o
);

    localparam int N  = ADDR_BITS + DATA_BITS;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (ALPHA_CYC > 1) ? $clog2(ALPHA_CYC) : 1;
    localparam int FW = $clog2(REPEAT + 1);

    localparam logic [PW-1:0] PMAX  = PW'(ALPHA_CYC - 1);
    localparam logic [BW-1:0] LASTB = BW'(N - 1);
    localparam logic [FW-1:0] RMAX  = FW'(REPEAT);

    typedef enum logic [1:0] {
        IDLE,
        BITS,
        SYNC
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    unit_q, unit_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FW-1:0] frm_q, frm_d;
    logic [N-1:0]  val_q, val_d;
    logic [N-1:0]  flt_q, flt_d;
    logic          cod_q, cod_d;
    logic          busy_q, busy_d;
    logic          sync_q, sync_d;
    logic          fd_q, fd_d;

    logic [N-1:0]  in_val;
    logic [N-1:0]  in_flt;
    logic          tick;
    logic [FW-1:0] frm_sat;
    logic          s_val;
    logic          s_flt;
    logic          bit_hi;
    logic [3:0]    rr;
    logic          first;

    // Gather address and data into one symbol vector, bit 0 sent first
    always_comb begin
        in_val = '0;
        in_flt = '0;
        in_val[ADDR_BITS-1:0] = addr_val;
        in_flt[ADDR_BITS-1:0] = addr_float;
        for (int i = 0; i < DATA_BITS; i++) begin
            in_val[ADDR_BITS+i] = data[i];
        end
    end

    assign tick    = (presc_q == PMAX);
    assign frm_sat = (frm_q == RMAX) ? frm_q : frm_q + 1'b1;

    // Next-state: prescaler, alpha/bit counters, frame counter, latches
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        unit_d  = unit_q;
        bit_d   = bit_q;
        frm_d   = frm_q;
        val_d   = val_q;
        flt_d   = flt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BITS;
                    presc_d = '0;
                    unit_d  = '0;
                    bit_d   = '0;
                    frm_d   = '0;
                    val_d   = in_val;
                    flt_d   = in_flt;
                end
            end
            BITS: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (unit_q == 7'd31) begin
                        unit_d = '0;
                        if (bit_q == LASTB) begin
                            state_d = SYNC;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end
            end
            SYNC: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (unit_q == 7'd127) begin
                        frm_d  = frm_sat;
                        unit_d = '0;
                        bit_d  = '0;
                        if (frm_sat >= RMAX && !continuous) begin
                            state_d = IDLE;
                        end else begin
                            state_d = BITS;
                            val_d   = in_val;
                            flt_d   = in_flt;
                        end
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the symbol that the next cycle will be transmitting
    always_comb begin
        s_val = 1'b0;
        s_flt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bit_d == BW'(i)) begin
                s_val = val_d[i];
                s_flt = flt_d[i];
            end
        end
    end

    // Pulse shaping: each bit is two 16-alpha halves, high 4 or 12
    always_comb begin
        rr    = unit_d[3:0];
        first = ~unit_d[4];
        if (s_flt) begin
            bit_hi = first ? (rr < 4'd4) : (rr < 4'd12);
        end else if (s_val) begin
            bit_hi = (rr < 4'd12);
        end else begin
            bit_hi = (rr < 4'd4);
        end
        busy_d = (state_d != IDLE);
        sync_d = (state_d == SYNC);
        fd_d   = (state_d == SYNC) && (unit_d == 7'd127)
                 && (presc_d == PMAX);
        cod_d  = ((state_d == BITS) && bit_hi)
                 || ((state_d == SYNC) && (unit_d < 7'd4));
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            unit_q  <= '0;
            bit_q   <= '0;
            frm_q   <= '0;
            val_q   <= '0;
            flt_q   <= '0;
            cod_q   <= 1'b0;
            busy_q  <= 1'b0;
            sync_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            unit_q  <= unit_d;
            bit_q   <= bit_d;
            frm_q   <= frm_d;
            val_q   <= val_d;
            flt_q   <= flt_d;
            cod_q   <= cod_d;
            busy_q  <= busy_d;
            sync_q  <= sync_d;
            fd_q    <= fd_d;
        end
    end

    assign cod_o      = cod_q;
    assign busy       = busy_q;
    assign sync       = sync_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_pt226x_encoder_gen2.sv
// Bench for pt226x_encoder_gen2: three parameter sets checked
// every cycle against a frame-level model, plus directed scenarios.
module tb_pt226x_encoder_gen2;

    logic       clk = 1'b0;
    logic       reset;
    logic       continuous;
    logic [2:0] start_v;
    logic [7:0] addr_val;
    logic [7:0] addr_float;
    logic [3:0] data;
    logic [2:0] cod_v, busy_v, sync_v, fd_v;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    pt226x_encoder_gen2 #(.ALPHA_CYC(1), .REPEAT(1)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .continuous(continuous), .addr_val(addr_val),
        .addr_float(addr_float), .data(data), .busy(busy_v[0]),
        .sync(sync_v[0]), .frame_done(fd_v[0]), .cod_o(cod_v[0]));

    pt226x_encoder_gen2 #(.ALPHA_CYC(1), .REPEAT(4)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .continuous(continuous), .addr_val(addr_val),
        .addr_float(addr_float), .data(data), .busy(busy_v[1]),
        .sync(sync_v[1]), .frame_done(fd_v[1]), .cod_o(cod_v[1]));

    pt226x_encoder_gen2 u2 (
        .clk(clk), .reset(reset), .start(start_v[2]),
        .continuous(continuous), .addr_val(addr_val),
        .addr_float(addr_float), .data(data), .busy(busy_v[2]),
        .sync(sync_v[2]), .frame_done(fd_v[2]), .cod_o(cod_v[2]));

    function automatic int ac(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic int rp(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int flen(input int i);
        return (32 * 12 + 128) * ac(i);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Waveform of a frame position from the symbol rules
    function automatic logic ecod(input logic [11:0] v,
                                  input logic [11:0] f,
                                  input int pos, input int a);
        int u, b, r, sym, h1, h2;
        u = pos / a;
        if (u < 32 * 12) begin
            b   = u / 32;
            r   = u % 32;
            sym = f[b] ? 2 : int'(v[b]);
            h1  = (sym == 1) ? 12 : 4;
            h2  = (sym == 0) ? 4 : 12;
            return (r < 16) ? (r < h1) : ((r - 16) < h2);
        end
        return (u - 32 * 12) < 4;
    endfunction

    logic        mb[3];
    int          mp[3];
    int          mf[3];
    logic [11:0] mval[3];
    logic [11:0] mflt[3];

    // Reference transmitter: position within frame, frame count
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mb[i] <= 1'b0;
                mp[i] <= 0;
                mf[i] <= 0;
            end else if (!mb[i]) begin
                if (start_v[i]) begin
                    mb[i]   <= 1'b1;
                    mp[i]   <= 0;
                    mf[i]   <= 0;
                    mval[i] <= {data, addr_val};
                    mflt[i] <= {4'b0, addr_float};
                end
            end else if (mp[i] == flen(i) - 1) begin
                mf[i] <= (mf[i] >= rp(i)) ? rp(i) : mf[i] + 1;
                if (mf[i] + 1 >= rp(i) && !continuous) begin
                    mb[i] <= 1'b0;
                end else begin
                    mp[i]   <= 0;
                    mval[i] <= {data, addr_val};
                    mflt[i] <= {4'b0, addr_float};
                end
            end else begin
                mp[i] <= mp[i] + 1;
            end
        end
    end

    // Compare every output of every instance on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d busy", i), int'(busy_v[i]),
                    int'(mb[i]));
                chk($sformatf("u%0d cod", i), int'(cod_v[i]),
                    mb[i] ? int'(ecod(mval[i], mflt[i], mp[i], ac(i))) : 0);
                chk($sformatf("u%0d sync", i), int'(sync_v[i]),
                    int'(mb[i] && mp[i] >= 384 * ac(i)));
                chk($sformatf("u%0d frame_done", i), int'(fd_v[i]),
                    int'(mb[i] && mp[i] == flen(i) - 1));
            end
        end
    end

    logic cap_cod[0:2100];
    logic cap_busy[0:2100];
    logic cap_sync[0:2100];
    logic cap_fd[0:2100];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_v != 3'b000 && k < 12000) begin
            tick();
            k++;
        end
        chk("idle wait", int'(busy_v), 0);
    endtask

    // Start instance u, record n cycles, optional mid-run actions
    task automatic capture(input int u, input int n, input int rs_c,
                           input int d_c, input logic [3:0] nd,
                           input int co_c);
        start_v[u] = 1'b1;
        tick();
        start_v[u] = 1'b0;
        for (int c = 1; c <= n; c++) begin
            cap_cod[c]  = cod_v[u];
            cap_busy[c] = busy_v[u];
            cap_sync[c] = sync_v[u];
            cap_fd[c]   = fd_v[u];
            start_v[u]  = (c == rs_c);
            if (c == d_c) data = nd;
            if (c == co_c) continuous = 1'b0;
            tick();
        end
    endtask

    function automatic int cnt_cod(input int from, input int len);
        int s = 0;
        for (int k = from; k < from + len; k++) s += int'(cap_cod[k]);
        return s;
    endfunction

    function automatic int cnt_busy(input int from, input int len);
        int s = 0;
        for (int k = from; k < from + len; k++) s += int'(cap_busy[k]);
        return s;
    endfunction

    function automatic int cnt_sync(input int from, input int len);
        int s = 0;
        for (int k = from; k < from + len; k++) s += int'(cap_sync[k]);
        return s;
    endfunction

    typedef struct packed {
        logic [7:0]       av;
        logic [7:0]       af;
        logic [3:0]       d;
        logic [11:0][4:0] hi;
    } vec_t;

    vec_t vt[5];
    int   fdq[$];

    initial begin
        logic [31:0] w;
        vt[0] = '{av: 8'hA5, af: 8'h0F, d: 4'b0011,
                  hi: {5'd8, 5'd8, 5'd24, 5'd24,
                       5'd24, 5'd8, 5'd24, 5'd8,
                       5'd16, 5'd16, 5'd16, 5'd16}};
        vt[1] = '{av: 8'h00, af: 8'h00, d: 4'h0,
                  hi: {12{5'd8}}};
        vt[2] = '{av: 8'hFF, af: 8'h00, d: 4'hF,
                  hi: {12{5'd24}}};
        vt[3] = '{av: 8'h00, af: 8'hFF, d: 4'h0,
                  hi: {{4{5'd8}}, {8{5'd16}}}};
        vt[4] = '{av: 8'h5A, af: 8'hF0, d: 4'hA,
                  hi: {5'd24, 5'd8, 5'd24, 5'd8,
                       5'd16, 5'd16, 5'd16, 5'd16,
                       5'd24, 5'd8, 5'd24, 5'd8}};

        reset      = 1'b1;
        continuous = 1'b0;
        start_v    = 3'b000;
        addr_val   = '0;
        addr_float = '0;
        data       = '0;
        tick();
        chk_en = 1'b1;

        // reset with random activity, then release
        for (int c = 0; c < 3; c++) begin
            start_v    = 3'($urandom);
            addr_val   = 8'($urandom);
            addr_float = 8'($urandom);
            data       = 4'($urandom);
            continuous = 1'($urandom);
            tick();
            chk("reset cod", int'(cod_v), 0);
            chk("reset busy", int'(busy_v), 0);
            chk("reset sync", int'(sync_v), 0);
            chk("reset fd", int'(fd_v), 0);
        end
        start_v    = 3'b000;
        continuous = 1'b0;
        reset      = 1'b0;
        tick();
        chk("post-reset busy", int'(busy_v), 0);
        chk("post-reset cod", int'(cod_v), 0);

        // single all-zero frame
        addr_val   = '0;
        addr_float = '0;
        data       = '0;
        capture(0, 513, -1, -1, 4'h0, -1);
        chk("t2 busy 1..512", cnt_busy(1, 512), 512);
        chk("t2 busy 513", int'(cap_busy[513]), 0);
        for (int b = 0; b < 12; b++) begin
            for (int k = 0; k < 32; k++)
                w[31-k] = cap_cod[1 + 32 * b + k];
            chk($sformatf("t2 bit%0d shape", b), int'(w), 32'hF000F000);
        end
        chk("t2 sync 385..512", cnt_sync(385, 128), 128);
        chk("t2 sync total", cnt_sync(1, 513), 128);
        chk("t2 sync high", cnt_cod(385, 4), 4);
        chk("t2 sync cod total", cnt_cod(385, 128), 4);
        chk("t2 fd at 512", int'(cap_fd[512]), 1);
        fdq = {};
        for (int k = 1; k <= 513; k++) if (cap_fd[k]) fdq.push_back(k);
        chk("t2 fd count", fdq.size(), 1);

        // table of symbol patterns
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            addr_val   = vt[v].av;
            addr_float = vt[v].af;
            data       = vt[v].d;
            capture(0, 513, -1, -1, 4'h0, -1);
            for (int b = 0; b < 12; b++)
                chk($sformatf("t3 v%0d bit%0d hi", v, b),
                    cnt_cod(1 + 32 * b, 32), int'(vt[v].hi[b]));
            chk($sformatf("t3 v%0d fd", v), int'(cap_fd[512]), 1);
            chk($sformatf("t3 v%0d end", v), int'(cap_busy[513]), 0);
        end

        // REPEAT=4 back-to-back frames, extra start ignored
        wait_idle();
        capture(1, 2060, 700, -1, 4'h0, -1);
        fdq = {};
        for (int k = 1; k <= 2060; k++) if (cap_fd[k]) fdq.push_back(k);
        chk("t4 fd count", fdq.size(), 4);
        for (int k = 0; k < 4 && k < fdq.size(); k++)
            chk($sformatf("t4 fd%0d cycle", k), fdq[k], 512 * (k + 1));
        chk("t4 no gaps", cnt_busy(1, 2048), 2048);
        chk("t4 end", int'(cap_busy[2049]), 0);

        // continuous with a data change mid-frame
        wait_idle();
        addr_val   = '0;
        addr_float = '0;
        data       = 4'h0;
        continuous = 1'b1;
        capture(0, 1600, -1, 100, 4'hF, 1400);
        fdq = {};
        for (int k = 1; k <= 1600; k++) if (cap_fd[k]) fdq.push_back(k);
        chk("t5 fd count", fdq.size(), 3);
        for (int k = 0; k < 3 && k < fdq.size(); k++)
            chk($sformatf("t5 fd%0d cycle", k), fdq[k], 512 * (k + 1));
        chk("t5 end", int'(cap_busy[1537]), 0);
        for (int f = 0; f < 3; f++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("t5 f%0d d%0d hi", f, j),
                    cnt_cod(1 + 512 * f + 32 * (8 + j), 32),
                    (f == 0) ? 8 : 24);

        // reset mid-bit, then a clean frame
        wait_idle();
        addr_val   = vt[0].av;
        addr_float = vt[0].af;
        data       = vt[0].d;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 1; c < 200; c++) tick();
        chk("t6 busy before reset", int'(busy_v[0]), 1);
        reset = 1'b1;
        tick();
        chk("t6 cod after reset", int'(cod_v[0]), 0);
        chk("t6 busy after reset", int'(busy_v[0]), 0);
        chk("t6 fd after reset", int'(fd_v[0]), 0);
        reset = 1'b0;
        tick();
        capture(0, 513, -1, -1, 4'h0, -1);
        for (int b = 0; b < 12; b++)
            chk($sformatf("t6 bit%0d hi", b),
                cnt_cod(1 + 32 * b, 32), int'(vt[0].hi[b]));
        chk("t6 fd", int'(cap_fd[512]), 1);

        // random traffic on all instances, model-checked
        for (int c = 0; c < 8000; c++) begin
            start_v = 3'($urandom);
            if ($urandom_range(0, 299) == 0) continuous = ~continuous;
            if ($urandom_range(0, 49) == 0) begin
                addr_val   = 8'($urandom);
                addr_float = 8'($urandom);
                data       = 4'($urandom);
            end
            reset = ($urandom_range(0, 1499) == 0);
            tick();
        end
        reset      = 1'b0;
        continuous = 1'b0;
        start_v    = 3'b000;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
